// File: rtl/bloom_filter_pkg.sv
// Shared definitions for the bloom filter CSR block and its fabric-side host.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: bus widths, CSR register map, host command and FSM encodings.
package bloom_filter_pkg;

   localparam int AMM_CSR_ADDR_W = 8;
   localparam int AMM_CSR_DATA_W = 32;
   localparam int MATCH_CNT_CNT  = 4;

   // CSR register map (word addresses)
   localparam int EN             = 0;
   localparam int HASH_LUT_CLEAN = 1;
   localparam int MATCH_CNT_BASE = 2;
   localparam int REGS_CNT       = MATCH_CNT_BASE + MATCH_CNT_CNT;

   typedef enum logic [1:0] {
      CMD_ENABLE    = 2'd0,
      CMD_DISABLE   = 2'd1,
      CMD_CLEAN_LUT = 2'd2,
      CMD_SWEEP     = 2'd3
   } csr_host_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_EN    = 3'd1,
      ST_WR_CLEAN = 3'd2,
      ST_RD_CLEAN = 3'd3,
      ST_WT_CLEAN = 3'd4,
      ST_RD_CNT   = 3'd5,
      ST_WT_CNT   = 3'd6
   } csr_host_state_t;

endpackage

// File: rtl/bloom_filter_sat_acc.sv
// Saturating accumulator: sum_o += add_dat_i when add_vld_i, pinned at all-ones.
// Latency: 1 cycle (sum_o reflects an add on the following cycle).
// Backpressure: none; accepts an add every cycle.
// Ports: clk_i, srst_n_i (sync, active-low), clr_i (clear wins over add),
//        add_vld_i / add_dat_i (addend), sum_o (registered total).
module bloom_filter_sat_acc
   import bloom_filter_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TOTAL_W = 64
) (
   input  logic               clk_i,
   input  logic               srst_n_i,
   input  logic               clr_i,
   input  logic               add_vld_i,
   input  logic [DATA_W-1:0]  add_dat_i,
   output logic [TOTAL_W-1:0] sum_o
);

   logic [TOTAL_W-1:0] sum_q;
   logic [TOTAL_W-1:0] sum_d;
   logic [TOTAL_W:0]   wide_sum;

   // One extra bit catches the carry-out that signals overflow.
   always_comb begin
      wide_sum = {1'b0, sum_q} + {{(TOTAL_W + 1 - DATA_W){1'b0}}, add_dat_i};
      sum_d    = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (add_vld_i) begin
         sum_d = wide_sum[TOTAL_W] ? '1 : wide_sum[TOTAL_W-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/bloom_filter_csr_host.sv
// Avalon-MM master driving the bloom filter CSR slave: EN writes, LUT clean, counter sweeps.
// Latency: EN write 1 cycle; clean 1 + 2 cycles per status poll; sweep 2 cycles per counter.
// Backpressure: cmd_ready_o is high only in IDLE; a pending auto-sweep yields to a new command.
// Ports: clk_i/srst_n_i; amm_master_csr_* (no waitrequest, read latency 1);
//        cmd_valid_i/cmd_ready_o/cmd_op_i; en_o, totals_o, sweep/clean done strobes, clean_timeout_o.
module bloom_filter_csr_host
   import bloom_filter_pkg::*;
#(
   parameter int AMM_CSR_ADDR_W = bloom_filter_pkg::AMM_CSR_ADDR_W,
   parameter int AMM_CSR_DATA_W = bloom_filter_pkg::AMM_CSR_DATA_W,
   parameter int MATCH_CNT_CNT  = bloom_filter_pkg::MATCH_CNT_CNT,
   parameter int TOTAL_W        = 64,
   parameter int POLL_PERIOD    = 1024,
   parameter int CLEAN_TIMEOUT  = 4096
) (
   input  logic                              clk_i,
   input  logic                              srst_n_i,
   output logic [AMM_CSR_ADDR_W-1:0]         amm_master_csr_address_o,
   output logic                              amm_master_csr_read_o,
   input  logic [AMM_CSR_DATA_W-1:0]         amm_master_csr_readdata_i,
   output logic                              amm_master_csr_write_o,
   output logic [AMM_CSR_DATA_W-1:0]         amm_master_csr_writedata_o,
   input  logic                              cmd_valid_i,
   output logic                              cmd_ready_o,
   input  logic [1:0]                        cmd_op_i,
   output logic                              en_o,
   output logic [MATCH_CNT_CNT*TOTAL_W-1:0]  totals_o,
   output logic                              sweep_done_stb_o,
   output logic                              clean_done_stb_o,
   output logic                              clean_timeout_o
);

   localparam int IDX_W = (MATCH_CNT_CNT > 1) ? $clog2(MATCH_CNT_CNT) : 1;
   localparam int CNT_W = $clog2(CLEAN_TIMEOUT + 1);
   localparam int TMR_W = (POLL_PERIOD > 0) ? $clog2(POLL_PERIOD + 1) : 1;

   csr_host_state_t state_q, state_d;
   csr_host_cmd_t   op_q, op_d, cmd_op;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] poll_q, poll_d, poll_inc;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             pend_q, pend_d;
   logic             en_q, en_d;
   logic             tmo_q, tmo_d;
   logic             sdone_q, sdone_d;
   logic             cdone_q, cdone_d;

   logic             cmd_acc;
   logic             auto_start;
   logic             expire;
   logic             idx_last;
   logic             status_busy;
   logic             poll_last;

   logic                      rd_s;
   logic                      wr_s;
   logic [AMM_CSR_ADDR_W-1:0] addr_s;
   logic [AMM_CSR_DATA_W-1:0] wdat_s;

   assign cmd_op      = csr_host_cmd_t'(cmd_op_i);
   assign cmd_acc     = cmd_valid_i && (state_q == ST_IDLE);
   assign auto_start  = (state_q == ST_IDLE) && !cmd_valid_i && pend_q;
   assign expire      = (POLL_PERIOD != 0) && (timer_q == TMR_W'(1));
   assign idx_last    = (idx_q == IDX_W'(MATCH_CNT_CNT - 1));
   assign status_busy = amm_master_csr_readdata_i[0];
   assign poll_inc    = poll_q + CNT_W'(1);
   assign poll_last   = status_busy && (poll_inc == CNT_W'(CLEAN_TIMEOUT));

   // ---------------- state register ----------------
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_acc) begin
               case (cmd_op)
                  CMD_ENABLE, CMD_DISABLE: state_d = ST_WR_EN;
                  CMD_CLEAN_LUT:           state_d = ST_WR_CLEAN;
                  default:                 state_d = ST_RD_CNT;
               endcase
            end else if (pend_q) begin
               state_d = ST_RD_CNT;
            end
         end
         ST_WR_EN:    state_d = ST_IDLE;
         ST_WR_CLEAN: state_d = ST_RD_CLEAN;
         ST_RD_CLEAN: state_d = ST_WT_CLEAN;
         ST_WT_CLEAN: state_d = (!status_busy || poll_last) ? ST_IDLE : ST_RD_CLEAN;
         ST_RD_CNT:   state_d = ST_WT_CNT;
         ST_WT_CNT:   state_d = idx_last ? ST_IDLE : ST_RD_CNT;
         default:     state_d = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      rd_s        = 1'b0;
      wr_s        = 1'b0;
      addr_s      = '0;
      wdat_s      = '0;
      cmd_ready_o = 1'b0;
      case (state_q)
         ST_IDLE: cmd_ready_o = 1'b1;
         ST_WR_EN: begin
            wr_s      = 1'b1;
            addr_s    = AMM_CSR_ADDR_W'(EN);
            wdat_s[0] = (op_q == CMD_ENABLE);
         end
         ST_WR_CLEAN: begin
            wr_s   = 1'b1;
            addr_s = AMM_CSR_ADDR_W'(HASH_LUT_CLEAN);
            wdat_s = AMM_CSR_DATA_W'(1);
         end
         ST_RD_CLEAN: begin
            rd_s   = 1'b1;
            addr_s = AMM_CSR_ADDR_W'(HASH_LUT_CLEAN);
         end
         ST_RD_CNT: begin
            rd_s   = 1'b1;
            addr_s = AMM_CSR_ADDR_W'(MATCH_CNT_BASE) + AMM_CSR_ADDR_W'(idx_q);
         end
         default: ;
      endcase
   end

   // Strobes are gated by reset so an aborted access never leaks onto the bus.
   assign amm_master_csr_read_o      = rd_s & srst_n_i;
   assign amm_master_csr_write_o     = wr_s & srst_n_i;
   assign amm_master_csr_address_o   = addr_s;
   assign amm_master_csr_writedata_o = wdat_s;

   // ---------------- datapath next-state ----------------
   always_comb begin
      op_d    = op_q;
      idx_d   = idx_q;
      poll_d  = poll_q;
      timer_d = timer_q;
      pend_d  = pend_q;
      en_d    = en_q;
      tmo_d   = tmo_q;
      sdone_d = (state_q == ST_WT_CNT) && idx_last;
      cdone_d = (state_q == ST_WT_CLEAN) && !status_busy;

      if (POLL_PERIOD != 0) begin
         timer_d = expire ? TMR_W'(POLL_PERIOD) : (timer_q - TMR_W'(1));
      end

      // Pending flag is a single bit, so back-to-back expiries collapse into one sweep.
      if (auto_start) begin
         pend_d = 1'b0;
         idx_d  = '0;
      end
      if (expire) begin
         pend_d = 1'b1;
      end

      if (cmd_acc) begin
         op_d = cmd_op;
         if (cmd_op == CMD_SWEEP) begin
            idx_d   = '0;
            pend_d  = 1'b0;
            timer_d = TMR_W'(POLL_PERIOD);
         end
         if (cmd_op == CMD_CLEAN_LUT) begin
            tmo_d = 1'b0;
         end
      end

      case (state_q)
         ST_WR_EN:    en_d   = (op_q == CMD_ENABLE);
         ST_WR_CLEAN: poll_d = '0;
         ST_WT_CLEAN: begin
            if (status_busy) begin
               poll_d = poll_inc;
               if (poll_last) begin
                  tmo_d = 1'b1;
               end
            end
         end
         ST_WT_CNT: begin
            if (!idx_last) begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         op_q    <= CMD_ENABLE;
         idx_q   <= '0;
         poll_q  <= '0;
         timer_q <= TMR_W'(POLL_PERIOD);
         pend_q  <= 1'b0;
         en_q    <= 1'b0;
         tmo_q   <= 1'b0;
         sdone_q <= 1'b0;
         cdone_q <= 1'b0;
      end else begin
         op_q    <= op_d;
         idx_q   <= idx_d;
         poll_q  <= poll_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         tmo_q   <= tmo_d;
         sdone_q <= sdone_d;
         cdone_q <= cdone_d;
      end
   end

   assign en_o             = en_q;
   assign clean_timeout_o  = tmo_q;
   assign sweep_done_stb_o = sdone_q;
   assign clean_done_stb_o = cdone_q;

   // ---------------- per-counter totals ----------------
   for (genvar i = 0; i < MATCH_CNT_CNT; i++) begin : g_acc
      bloom_filter_sat_acc #(
         .DATA_W  (AMM_CSR_DATA_W),
         .TOTAL_W (TOTAL_W)
      ) u_acc (
         .clk_i     (clk_i),
         .srst_n_i  (srst_n_i),
         .clr_i     (1'b0),
         .add_vld_i ((state_q == ST_WT_CNT) && (idx_q == IDX_W'(i))),
         .add_dat_i (amm_master_csr_readdata_i),
         .sum_o     (totals_o[i*TOTAL_W +: TOTAL_W])
      );
   end

endmodule
